// File: rtl/riscv_mem_pkg.sv
// Shared encodings and load-extension helper for the byte-addressed data
// memory and its dump engine.
package riscv_mem_pkg;

  // Widest word the extension helper handles; the memory truncates to DATA_W.
  localparam int MAX_DATA_W = 128;

  typedef enum logic [1:0] {
    SIZE_B   = 2'b00,
    SIZE_H   = 2'b01,
    SIZE_W   = 2'b10,
    SIZE_RSV = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    DUMP_IDLE = 2'b00,
    DUMP_SEND = 2'b01,
    DUMP_DONE = 2'b10
  } dump_state_e;

  // raw holds the addressed bytes in little-endian order starting at lane 0.
  // Byte and halfword results are sign- or zero-extended to the full width;
  // word results pass through, so the caller simply keeps its low DATA_W bits.
  function automatic logic [MAX_DATA_W-1:0] load_extend(
    input logic [MAX_DATA_W-1:0] raw,
    input size_e                 size,
    input logic                  unsgn
  );
    logic [MAX_DATA_W-1:0] r;
    case (size)
      SIZE_B:  r = unsgn ? {{(MAX_DATA_W-8){1'b0}}, raw[7:0]}
                         : {{(MAX_DATA_W-8){raw[7]}}, raw[7:0]};
      SIZE_H:  r = unsgn ? {{(MAX_DATA_W-16){1'b0}}, raw[15:0]}
                         : {{(MAX_DATA_W-16){raw[15]}}, raw[15:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_dump_ctrl.sv
// Dump engine: walks the byte array one word at a time and streams
// (address, word) pairs over a valid/ready port.
module mem_dump_ctrl
  import riscv_mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH_BYTES = 256,
  parameter int ADDR_W      = 32,
  parameter int DUMP_START  = 0,
  parameter int DUMP_STRIDE = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              dump_start,
  input  logic              dump_ready,
  input  logic [DATA_W-1:0] fetch_data,
  output logic [ADDR_W-1:0] fetch_addr,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_busy,
  output logic              dump_done
);

  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH_BYTES);
  localparam logic [ADDR_W:0]   STRIDE_X = (ADDR_W+1)'(DUMP_STRIDE);
  localparam logic [ADDR_W-1:0] START_A  = ADDR_W'(DUMP_START);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W:0]   next_x;
  logic              last_word;
  logic              load;

  // One extra bit so the end-of-memory test cannot wrap.
  assign next_x    = {1'b0, ptr_q} + STRIDE_X;
  assign last_word = (next_x >= DEPTH_X);

  always_comb begin
    // NOTE: every signal gets a default before the case, otherwise paths that
    // leave it unassigned would infer a latch.
    state_d = state_q;
    ptr_d   = ptr_q;
    load    = 1'b0;
    case (state_q)
      DUMP_IDLE: begin
        if (dump_start) begin
          ptr_d   = START_A;
          load    = 1'b1;
          state_d = DUMP_SEND;
        end
      end
      DUMP_SEND: begin
        if (dump_ready) begin
          if (last_word) begin
            state_d = DUMP_DONE;
          end else begin
            ptr_d = next_x[ADDR_W-1:0];
            load  = 1'b1;
          end
        end
      end
      DUMP_DONE: state_d = DUMP_IDLE;
      default:   state_d = DUMP_IDLE;
    endcase
  end

  // The word about to be captured is read through the second RAM port; since
  // the capture uses pre-edge RAM contents, a same-edge CPU store is not seen.
  assign fetch_addr = ptr_d;

  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (RST) begin
      state_q <= DUMP_IDLE;
      ptr_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (load) data_q <= fetch_data;
    end
  end

  // SEND only ever holds a presented pair, so valid and busy follow the state.
  assign dump_valid = (state_q == DUMP_SEND);
  assign dump_busy  = (state_q == DUMP_SEND);
  assign dump_done  = (state_q == DUMP_DONE);
  assign dump_addr  = ptr_q;
  assign dump_data  = data_q;

endmodule

// File: rtl/data_memory_dump.sv
// Byte-addressed data memory with sized, extended loads, misalignment
// detection and a hardware dump port.
module data_memory_dump
  import riscv_mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH_BYTES = 256,
  parameter int ADDR_W      = 32,
  parameter int DUMP_START  = 0,
  parameter int DUMP_STRIDE = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WD,
  input  logic              MemWrite,
  input  logic [1:0]        Size,
  input  logic              Unsigned,
  output logic [DATA_W-1:0] RD,
  output logic              Misaligned,
  input  logic              dump_start,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_busy,
  output logic              dump_done
);

  localparam int WORD_BYTES = DATA_W / 8;
  localparam int IDX_W      = $clog2(DEPTH_BYTES);
  localparam int OFF_W      = $clog2(WORD_BYTES);

  logic [7:0]            ram [DEPTH_BYTES];
  logic [IDX_W-1:0]      cpu_idx;
  logic [WORD_BYTES-1:0] lane_en;
  logic                  misaligned;
  logic [DATA_W-1:0]     cpu_raw;
  logic [MAX_DATA_W-1:0] cpu_ext;
  logic [ADDR_W-1:0]     dump_fetch_addr;
  logic [IDX_W-1:0]      dump_idx;
  logic [DATA_W-1:0]     dump_raw;
  logic                  unused_bits;

  // Upper address bits are ignored, so addresses wrap around the array.
  assign cpu_idx  = Addr[IDX_W-1:0];
  assign dump_idx = dump_fetch_addr[IDX_W-1:0];

  always_comb begin
    lane_en    = '0;
    misaligned = 1'b0;
    case (size_e'(Size))
      SIZE_B: lane_en[0] = 1'b1;
      SIZE_H: begin
        lane_en[1:0] = 2'b11;
        misaligned   = Addr[0];
      end
      default: begin
        lane_en    = '1;
        misaligned = |Addr[OFF_W-1:0];
      end
    endcase
  end

  // CPU read port: bytes from the effective index upward, lane 0 first.
  always_comb begin
    cpu_raw = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      cpu_raw[8*i +: 8] = ram[cpu_idx + IDX_W'(i)];
    end
  end

  assign cpu_ext    = load_extend({{(MAX_DATA_W-DATA_W){1'b0}}, cpu_raw},
                                  size_e'(Size), Unsigned);
  assign RD         = misaligned ? '0 : cpu_ext[DATA_W-1:0];
  assign Misaligned = misaligned;

  // Dump read port: always word-aligned because the stride is a word multiple.
  always_comb begin
    dump_raw = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      dump_raw[8*i +: 8] = ram[dump_idx + IDX_W'(i)];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: the array must clear on reset, so it is built from flops with an
    // async clear rather than mapped onto a RAM macro.
    if (RST) begin
      for (int i = 0; i < DEPTH_BYTES; i++) ram[i] <= '0;
    end else if (MemWrite && !misaligned) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (lane_en[i]) ram[cpu_idx + IDX_W'(i)] <= WD[8*i +: 8];
      end
    end
  end

  mem_dump_ctrl #(
    .DATA_W      (DATA_W),
    .DEPTH_BYTES (DEPTH_BYTES),
    .ADDR_W      (ADDR_W),
    .DUMP_START  (DUMP_START),
    .DUMP_STRIDE (DUMP_STRIDE)
  ) u_dump_ctrl (
    .CLK        (CLK),
    .RST        (RST),
    .dump_start (dump_start),
    .dump_ready (dump_ready),
    .fetch_data (dump_raw),
    .fetch_addr (dump_fetch_addr),
    .dump_valid (dump_valid),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done)
  );

  assign unused_bits = ^{Addr[ADDR_W-1:IDX_W], dump_fetch_addr[ADDR_W-1:IDX_W],
                         cpu_ext[MAX_DATA_W-1:DATA_W]};

endmodule
